color_arb_ctrl: RTL and testbench

COLOR_ARB_CTRL -- requirements
Module: color_arb_ctrl

---
 rtl/color_ctrl_pkg.sv | 30 +++
 rtl/color_arb_ctrl_btn_debounce.sv | 102 ++++++++++
 rtl/color_arb_ctrl.sv | 101 ++++++++++
 tb/tb_color_arb_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/color_ctrl_pkg.sv
// color_ctrl_pkg: shared types and constants for the paddle colour controller.
//   btn_state_t : per-player button FSM states
//   req_type_t  : kind of request a debounced press turns into
//   CH_R/G/B    : channel encodings for the per-player channel pointer
//   next_ch()   : channel rotation R -> G -> B -> R
package color_ctrl_pkg;

  localparam int CH_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_PENDING      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_t;

  typedef enum logic {
    REQ_INC = 1'b0,
    REQ_SEL = 1'b1
  } req_type_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_B) ? CH_R : ch + 2'd1;
  endfunction

endpackage

// File: rtl/color_arb_ctrl_btn_debounce.sv
// btn_debounce: one player's button front end.
//   clk, reset : clock, asynchronous active-low reset
//   inc_n      : increment button, active-low, asynchronous to clk
//   sel_n      : channel-select button, active-low, asynchronous to clk
//   granted    : arbiter accepted this player's pending request this cycle
//   pending    : a debounced request is waiting for the arbiter
//   req_type   : kind of the pending request (SEL wins when both were low)
module btn_debounce
  import color_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc_n,
  input  logic      sel_n,
  input  logic      granted,
  output logic      pending,
  output req_type_t req_type
);

  localparam int CNT_W = 20;
  // The counter starts at 0 on the first low cycle seen in IDLE; moving on
  // when the incremented value would reach DEBOUNCE_CYCLES-1 means exactly
  // DEBOUNCE_CYCLES low cycles (IDLE cycle included) precede PENDING.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [1:0]       inc_sync_reg;
  logic [1:0]       sel_sync_reg;
  logic             inc_low;
  logic             sel_low;
  logic             any_low;
  btn_state_t       state_reg;
  btn_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  req_type_t        type_reg;
  req_type_t        type_next;

  // Synchronisers idle high so a reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_sync_reg <= 2'b11;
      sel_sync_reg <= 2'b11;
    end else begin
      inc_sync_reg <= {inc_sync_reg[0], inc_n};
      sel_sync_reg <= {sel_sync_reg[0], sel_n};
    end
  end

  assign inc_low = ~inc_sync_reg[1];
  assign sel_low = ~sel_sync_reg[1];
  assign any_low = inc_low | sel_low;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    type_next  = type_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_low) begin
          state_next = ST_DEBOUNCE;
          cnt_next   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!any_low) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_PENDING;
          type_next  = sel_low ? REQ_SEL : REQ_INC;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_PENDING: begin
        if (granted) state_next = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        // No auto-repeat: a press is only re-armed after a full release.
        if (!any_low) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      type_reg  <= REQ_INC;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      type_reg  <= type_next;
    end
  end

  assign pending  = (state_reg == ST_PENDING);
  assign req_type = type_reg;

endmodule

// File: rtl/color_arb_ctrl.sv
// color_arb_ctrl: two-player paddle colour editor with a shared update unit.
//   clk, reset           : clock, asynchronous active-low reset
//   btn_inc_n[1:0]       : per-player increment buttons, active-low
//   btn_sel_n[1:0]       : per-player channel-select buttons, active-low
//   p0_color, p1_color   : paddle colours {R,G,B}, R in the MSBs
//   p0_ch, p1_ch         : channel each player currently edits (0=R,1=G,2=B)
//   grant[1:0]           : one-hot pulse, player whose update lands this cycle
module color_arb_ctrl
  import color_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CH_W            = CH_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        btn_inc_n,
  input  logic [1:0]        btn_sel_n,
  output logic [3*CH_W-1:0] p0_color,
  output logic [3*CH_W-1:0] p1_color,
  output logic [1:0]        p0_ch,
  output logic [1:0]        p1_ch,
  output logic [1:0]        grant
);

  logic [1:0] pending;
  req_type_t  req_type [2];
  // Winner of the most recent contested cycle; solo grants leave it alone so
  // ties keep alternating. Reset value 1 lets player 0 win the first tie.
  logic       last_reg;

  always_comb begin
    grant = 2'b00;
    case (pending)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else if (pending == 2'b11) begin
      last_reg <= grant[1];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    logic [3*CH_W-1:0] color_reg;
    logic [3*CH_W-1:0] color_next;
    logic [1:0]        ch_reg;
    logic [1:0]        ch_next;

    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .inc_n   (btn_inc_n[gi]),
      .sel_n   (btn_sel_n[gi]),
      .granted (grant[gi]),
      .pending (pending[gi]),
      .req_type(req_type[gi])
    );

    always_comb begin
      color_next = color_reg;
      ch_next    = ch_reg;
      if (grant[gi]) begin
        if (req_type[gi] == REQ_SEL) begin
          ch_next = next_ch(ch_reg);
        end else begin
          // Channel arithmetic wraps naturally at CH_W bits.
          case (ch_reg)
            CH_R:    color_next[3*CH_W-1:2*CH_W] = color_reg[3*CH_W-1:2*CH_W] + 1'b1;
            CH_G:    color_next[2*CH_W-1:CH_W]   = color_reg[2*CH_W-1:CH_W] + 1'b1;
            CH_B:    color_next[CH_W-1:0]        = color_reg[CH_W-1:0] + 1'b1;
            default: color_next = color_reg;
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        color_reg <= '0;
        ch_reg    <= CH_R;
      end else begin
        color_reg <= color_next;
        ch_reg    <= ch_next;
      end
    end
  end

  assign p0_color = g_player[0].color_reg;
  assign p1_color = g_player[1].color_reg;
  assign p0_ch    = g_player[0].ch_reg;
  assign p1_ch    = g_player[1].ch_reg;

endmodule

// File: tb/tb_color_arb_ctrl.sv
// tb_color_arb_ctrl: directed bench for color_arb_ctrl with DEBOUNCE_CYCLES=4.
module tb_color_arb_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  btn_inc_n;
  logic [1:0]  btn_sel_n;
  logic [11:0] p0_color;
  logic [11:0] p1_color;
  logic [1:0]  p0_ch;
  logic [1:0]  p1_ch;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int g0_cnt   = 0;
  int g1_cnt   = 0;
  int bad_cnt  = 0;
  logic [1:0] glog [$];
  int         gcyc [$];

  color_arb_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CH_W           (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_inc_n(btn_inc_n),
    .btn_sel_n(btn_sel_n),
    .p0_color (p0_color),
    .p1_color (p1_color),
    .p0_ch    (p0_ch),
    .p1_ch    (p1_ch),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Grant observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (grant == 2'b01) g0_cnt++;
    else if (grant == 2'b10) g1_cnt++;
    else if (grant != 2'b00) bad_cnt++;
    if (grant != 2'b00) begin
      glog.push_back(grant);
      gcyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    g0_cnt  = 0;
    g1_cnt  = 0;
    bad_cnt = 0;
    glog.delete();
    gcyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    btn_inc_n = 2'b11;
    btn_sel_n = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_log();
  endtask

  task automatic press(input logic [1:0] inc_mask, input logic [1:0] sel_mask, input int hold);
    @(negedge clk);
    btn_inc_n = ~inc_mask;
    btn_sel_n = ~sel_mask;
    repeat (hold) @(negedge clk);
    btn_inc_n = 2'b11;
    btn_sel_n = 2'b11;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (p0_color !== 12'h000) begin failures++; $display("FAIL reset_p0_color got=%h exp=000", p0_color); end
    checks++; if (p1_color !== 12'h000) begin failures++; $display("FAIL reset_p1_color got=%h exp=000", p1_color); end
    checks++; if (p0_ch !== 2'd0) begin failures++; $display("FAIL reset_p0_ch got=%0d exp=0", p0_ch); end
    checks++; if (p1_ch !== 2'd0) begin failures++; $display("FAIL reset_p1_ch got=%0d exp=0", p1_ch); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_log();
    $display("test_reset: p0=%h p1=%h ch=%0d/%0d grant=%b", p0_color, p1_color, p0_ch, p1_ch, grant);
  endtask

  task automatic test_single_inc();
    do_reset();
    press(2'b01, 2'b00, 10);
    checks++; if (g0_cnt != 1) begin failures++; $display("FAIL single_g0_count got=%0d exp=1", g0_cnt); end
    checks++; if (g1_cnt != 0) begin failures++; $display("FAIL single_g1_count got=%0d exp=0", g1_cnt); end
    checks++; if (p0_color !== 12'h100) begin failures++; $display("FAIL single_p0_color got=%h exp=100", p0_color); end
    checks++; if (p1_color !== 12'h000) begin failures++; $display("FAIL single_p1_color got=%h exp=000", p1_color); end
    $display("test_single_inc: grants p0=%0d p1=%0d p0=%h p1=%h", g0_cnt, g1_cnt, p0_color, p1_color);
  endtask

  task automatic test_glitch();
    do_reset();
    press(2'b01, 2'b00, 2);
    repeat (5) @(negedge clk);
    checks++; if (g0_cnt + g1_cnt != 0) begin failures++; $display("FAIL glitch_grants got=%0d exp=0", g0_cnt + g1_cnt); end
    checks++; if (p0_color !== 12'h000) begin failures++; $display("FAIL glitch_p0_color got=%h exp=000", p0_color); end
    checks++; if (p1_color !== 12'h000) begin failures++; $display("FAIL glitch_p1_color got=%h exp=000", p1_color); end
    $display("test_glitch: grants=%0d p0=%h p1=%h", g0_cnt + g1_cnt, p0_color, p1_color);
  endtask

  task automatic test_sel_wrap();
    do_reset();
    press(2'b00, 2'b01, 8);
    checks++; if (p0_ch !== 2'd1) begin failures++; $display("FAIL sel_p0_ch got=%0d exp=1", p0_ch); end
    checks++; if (p0_color !== 12'h000) begin failures++; $display("FAIL sel_p0_color got=%h exp=000", p0_color); end
    for (int i = 0; i < 15; i++) press(2'b01, 2'b00, 8);
    checks++; if (p0_color !== 12'h0F0) begin failures++; $display("FAIL wrap_15_p0_color got=%h exp=0f0", p0_color); end
    press(2'b01, 2'b00, 8);
    checks++; if (p0_color !== 12'h000) begin failures++; $display("FAIL wrap_16_p0_color got=%h exp=000", p0_color); end
    checks++; if (p0_ch !== 2'd1) begin failures++; $display("FAIL wrap_p0_ch got=%0d exp=1", p0_ch); end
    checks++; if (g0_cnt != 17) begin failures++; $display("FAIL wrap_g0_count got=%0d exp=17", g0_cnt); end
    $display("test_sel_wrap: p0=%h ch=%0d grants=%0d", p0_color, p0_ch, g0_cnt);
  endtask

  task automatic test_contention();
    do_reset();
    press(2'b11, 2'b00, 10);
    checks++; if (glog.size() != 2) begin failures++; $display("FAIL tie1_grant_count got=%0d exp=2", glog.size()); end
    else begin
      checks++; if (glog[0] !== 2'b01) begin failures++; $display("FAIL tie1_first got=%b exp=01", glog[0]); end
      checks++; if (glog[1] !== 2'b10) begin failures++; $display("FAIL tie1_second got=%b exp=10", glog[1]); end
      checks++; if (gcyc[1] != gcyc[0] + 1) begin failures++; $display("FAIL tie1_gap got=%0d exp=1", gcyc[1] - gcyc[0]); end
    end
    checks++; if (p0_color !== 12'h100) begin failures++; $display("FAIL tie1_p0_color got=%h exp=100", p0_color); end
    checks++; if (p1_color !== 12'h100) begin failures++; $display("FAIL tie1_p1_color got=%h exp=100", p1_color); end
    $display("test_contention: first pair p0=%h p1=%h grants=%0d", p0_color, p1_color, glog.size());
    clear_log();
    press(2'b11, 2'b00, 10);
    checks++; if (glog.size() != 2) begin failures++; $display("FAIL tie2_grant_count got=%0d exp=2", glog.size()); end
    else begin
      checks++; if (glog[0] !== 2'b10) begin failures++; $display("FAIL tie2_first got=%b exp=10", glog[0]); end
      checks++; if (glog[1] !== 2'b01) begin failures++; $display("FAIL tie2_second got=%b exp=01", glog[1]); end
    end
    checks++; if (p0_color !== 12'h200) begin failures++; $display("FAIL tie2_p0_color got=%h exp=200", p0_color); end
    checks++; if (p1_color !== 12'h200) begin failures++; $display("FAIL tie2_p1_color got=%h exp=200", p1_color); end
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL tie_onehot got=%0d exp=0", bad_cnt); end
    $display("test_contention: second pair p0=%h p1=%h", p0_color, p1_color);
  endtask

  task automatic test_sel_priority();
    do_reset();
    press(2'b10, 2'b10, 10);
    checks++; if (p1_ch !== 2'd1) begin failures++; $display("FAIL both_p1_ch got=%0d exp=1", p1_ch); end
    checks++; if (p1_color !== 12'h000) begin failures++; $display("FAIL both_p1_color got=%h exp=000", p1_color); end
    checks++; if (g1_cnt != 1) begin failures++; $display("FAIL both_g1_count got=%0d exp=1", g1_cnt); end
    $display("test_sel_priority: p1_ch=%0d p1=%h grants=%0d", p1_ch, p1_color, g1_cnt);
  endtask

  task automatic test_reset_pending();
    bit seen;
    do_reset();
    seen = 1'b0;
    @(negedge clk);
    btn_inc_n = 2'b10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant[0]) begin
        reset = 1'b0;   // lands before the edge that would apply the update
        seen  = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_pend_timeout got=no_grant exp=grant"); end
    repeat (2) @(negedge clk);
    checks++; if (p0_color !== 12'h000) begin failures++; $display("FAIL rst_pend_discard got=%h exp=000", p0_color); end
    clear_log();
    reset = 1'b1;   // button still held
    repeat (4) @(negedge clk);
    checks++; if (g0_cnt != 0) begin failures++; $display("FAIL rst_pend_early got=%0d exp=0", g0_cnt); end
    repeat (10) @(negedge clk);
    btn_inc_n = 2'b11;
    repeat (5) @(negedge clk);
    checks++; if (g0_cnt != 1) begin failures++; $display("FAIL rst_pend_once got=%0d exp=1", g0_cnt); end
    checks++; if (p0_color !== 12'h100) begin failures++; $display("FAIL rst_pend_p0_color got=%h exp=100", p0_color); end
    $display("test_reset_pending: grants=%0d p0=%h", g0_cnt, p0_color);
  endtask

  initial begin
    reset     = 1'b0;
    btn_inc_n = 2'b11;
    btn_sel_n = 2'b11;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_inc();
    test_glitch();
    test_sel_wrap();
    test_contention();
    test_sel_priority();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
